fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one FIFO write port among N_REQ producers.
//  Each producer has a valid/ready port. The arbiter grants one producer per
//  burst and forwards its words to the FIFO write side, throttling on FIFO full.
//  It sits in the write-clock domain, directly in front of async_fifo's write port.
// PARAMETERS
//  N_REQ       4    number of requesters (2..16)
//  DATA_WIDTH  64   word width; must match the FIFO DATA_WIDTH
//  MAX_BURST   4    max words accepted per grant before re-arbitration (1..255)
// PORTS
//  i_clk           in   1               clock (write-side clock of the FIFO)
//  i_rst           in   1               synchronous reset, active-high
//  i_req_valid     in   N_REQ           per-requester word valid
//  i_req_data      in   N_REQ*DATA_WIDTH  requester k data at [k*DATA_WIDTH +: DATA_WIDTH]
//  o_req_ready     out  N_REQ           per-requester ready; a word moves when valid&ready
//  o_grant         out  N_REQ           one-hot current grant, registered
//  o_busy          out  1               1 while in BURST state
//  o_fifo_wr_en    out  1               to FIFO i_wr_en
//  o_fifo_wr_data  out  DATA_WIDTH      to FIFO i_wr_data
//  i_fifo_full     in   1               from FIFO o_full
//  o_word_cnt      out  N_REQ*32        per-requester accepted-word counters (see CONFIGURATION)
// BEHAVIOUR
//  - States: IDLE, BURST. Registers: state, grant (one-hot), last_idx, burst_cnt (8b).
//  - Reset (i_rst=1 at posedge): state=IDLE, grant=0, last_idx=N_REQ-1, burst_cnt=0.
//    o_busy=0, o_req_ready=0, o_fifo_wr_en=0, o_word_cnt=0. Reset mid-burst drops
//    the grant; words not yet accepted are not written.
//  - IDLE: if any i_req_valid, grant the first valid index scanning last_idx+1, +2, ...
//    (mod N_REQ). Next cycle: state=BURST, grant set, last_idx=granted index,
//    burst_cnt=0. With no valid, stay in IDLE. Arbitration costs 1 cycle; no word moves in IDLE.
//  - BURST (granted index g):
//    o_req_ready[g] = ~i_fifo_full, and all other ready bits are 0 (combinational).
//    o_fifo_wr_en = i_req_valid[g] & ~i_fifo_full (combinational, zero latency).
//    o_fifo_wr_data = i_req_data[g] (mux by grant; value is don't-care when wr_en=0).
//    Each transfer increments burst_cnt.
//  - Exit BURST -> IDLE (grant cleared next cycle) when either:
//    (a) a transfer occurs with burst_cnt==MAX_BURST-1, or
//    (b) i_req_valid[g]==0 in any BURST cycle (requester released).
//  - Full: while i_fifo_full=1, ready=0 and wr_en=0. State, grant and burst_cnt hold,
//    so the burst stalls without timing out. No write ever occurs while full.
//  - A requester must hold valid and data stable until accepted.
//    Dropping valid before acceptance ends its burst.
//  - After exiting BURST there is always >=1 IDLE cycle before the next grant.
//    Fairness: a continuously valid requester waits at most
//    (N_REQ-1)*(MAX_BURST+1) non-full cycles for its grant.
// CONFIGURATION
//  - FIFO_ARB_STATS_EN defined: o_word_cnt[k*32 +: 32] increments on each transfer
//    from requester k. The counters wrap at 2^32 and are cleared by i_rst.
//  - FIFO_ARB_STATS_EN undefined: o_word_cnt is tied to 0 and no counters are built.
//    The port list is identical in both cases.
// TESTING  (N_REQ=4, DATA_WIDTH=64, MAX_BURST=4, FIFO DEPTH=512)
//  1. After reset, only req1 holds valid with 10 words.
//     -> grant=4'b0010 one cycle later. Bursts of 4,4,2 words with 1 IDLE cycle
//     between bursts. The FIFO receives the 10 words in order.
//  2. All 4 valid continuously, FIFO never full.
//     -> grant order 0,1,2,3,0...; exactly 4 words per grant; wr_en duty 4/5.
//  3. Hold i_fifo_full=1 for 6 cycles mid-burst after 2 words.
//     -> wr_en=0 and ready=0 for those 6 cycles. Grant holds, then the last 2 words complete.
//  4. Granted req2 drops valid after 1 word.
//     -> IDLE next cycle; next grant goes to req3 if valid, otherwise by wrap-around.
//  5. Assert i_rst during a burst after 2 words.
//     -> next cycle all outputs 0. After reset, the first grant goes to req0 when all are valid.
//  6. FIFO_ARB_STATS_EN: run scenario 2 for 100 cycles.
//     -> o_word_cnt values sum to the number of FIFO writes, each within +-4 of the others.
//     Without the macro, o_word_cnt==0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one FIFO write port among N_REQ producers.
//   A producer wins a grant in IDLE, then streams up to MAX_BURST words in
//   BURST. The FIFO full flag stalls the burst without ending it. The grant
//   ends early if the producer drops valid. Every grant is preceded by at
//   least one IDLE (arbitration) cycle.
//
//   Optional feature: define FIFO_ARB_STATS_EN to build one 32-bit
//   accepted-word counter per requester. Without the macro, o_word_cnt is
//   tied to 0. The port list is the same in both builds.
//
// Ports
//   i_clk           write-side clock of the FIFO
//   i_rst           synchronous reset, active-high
//   i_req_valid     per-requester word valid
//   i_req_data      requester k data at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready     per-requester ready; a word moves when valid & ready
//   o_grant         registered one-hot grant
//   o_busy          high while in BURST
//   o_fifo_wr_en    FIFO write enable
//   o_fifo_wr_data  FIFO write data, selected by the grant
//   i_fifo_full     FIFO full flag
//   o_word_cnt      per-requester accepted-word counters, 32 bits each
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [N_REQ-1:0]            o_req_ready,
  output logic [N_REQ-1:0]            o_grant,
  output logic                        o_busy,
  output logic                        o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       o_fifo_wr_data,
  input  logic                        i_fifo_full,
  output logic [N_REQ*32-1:0]         o_word_cnt
);

  localparam int unsigned     IdxW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]      LastBeat   = 8'(MAX_BURST - 1);
  localparam logic [IdxW-1:0] LastIdxRst = IdxW'(N_REQ - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IdxW-1:0]  last_idx_q, last_idx_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;

  logic             pick_found;
  logic [IdxW-1:0]  pick_idx;
  logic [IdxW-1:0]  cand_idx;
  logic             grant_valid;
  logic             xfer;

  // grant_q is all-zero outside BURST, so this is the granted requester's valid.
  assign grant_valid = |(i_req_valid & grant_q);
  assign xfer        = (state_q == StBurst) & grant_valid & ~i_fifo_full;

  // Round-robin pick. The scan starts just after the last winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand_idx = IdxW'((32'(last_idx_q) + i) % N_REQ);
      if (!pick_found && i_req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      last_idx_q  <= LastIdxRst;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_idx_q  <= last_idx_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_idx_d  = last_idx_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d           = StBurst;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          last_idx_d        = pick_idx;
          burst_cnt_d       = '0;
        end
      end
      StBurst: begin
        // Release, or the final beat of a full-length burst. While the FIFO
        // is full and valid is held, everything holds.
        if (!grant_valid || (xfer && (burst_cnt_q == LastBeat))) begin
          state_d     = StIdle;
          grant_d     = '0;
          burst_cnt_d = '0;
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    o_busy         = (state_q == StBurst);
    o_req_ready    = '0;
    o_fifo_wr_en   = 1'b0;
    o_fifo_wr_data = '0;
    if (state_q == StBurst) begin
      o_req_ready  = grant_q & {N_REQ{~i_fifo_full}};
      o_fifo_wr_en = xfer;
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) begin
        o_fifo_wr_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign o_grant = grant_q;

`ifdef FIFO_ARB_STATS_EN
  logic [31:0] word_cnt_q [N_REQ];

  // The counters wrap naturally at 2^32.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        word_cnt_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (xfer && grant_q[k]) begin
          word_cnt_q[k] <= word_cnt_q[k] + 32'd1;
        end
      end
    end
  end

  for (genvar k = 0; k < N_REQ; k++) begin : g_word_cnt
    assign o_word_cnt[k*32 +: 32] = word_cnt_q[k];
  end
`else
  assign o_word_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter.
// Each producer is a queue of words. A reference model follows the grant
// owner, the round-robin pointer and the words accepted in the burst, and it
// predicts grant, busy, ready, wr_en and the data written on every cycle.
module tb_fifo_wr_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 64;
  localparam int unsigned MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           wr_en;
  logic [W-1:0]   wr_data;
  logic           fifo_full;
  logic [N*32-1:0] word_cnt;

  fifo_wr_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (W),
    .MAX_BURST  (MB)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .i_req_data     (req_data),
    .o_req_ready    (req_ready),
    .o_grant        (grant),
    .o_busy         (busy),
    .o_fifo_wr_en   (wr_en),
    .o_fifo_wr_data (wr_data),
    .i_fifo_full    (fifo_full),
    .o_word_cnt     (word_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Producer queues and stimulus knobs
  logic [W-1:0] q [N][$];
  bit           drop_en;   // randomly withhold valid
  int           full_pct;  // <0: fifo_full is driven by the test itself

  // Reference model
  int          m_owner;    // -1 when nobody holds the grant
  int          m_last;
  int          m_cnt;
  int unsigned m_words [N];

  logic [N-1:0] e_grant, e_ready;
  logic         e_busy, e_wr;
  logic [W-1:0] e_data;

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid[k] = (q[k].size() > 0) && !(drop_en && ($urandom_range(0, 7) == 0));
      req_data[k*W +: W] = (q[k].size() > 0) ? q[k][0] : rnd_word();
    end
    if (full_pct >= 0) fifo_full = ($urandom_range(0, 99) < full_pct);
  endtask

  task automatic model_expect();
    e_busy  = (m_owner >= 0);
    e_grant = '0;
    e_ready = '0;
    e_wr    = 1'b0;
    e_data  = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_ready[m_owner] = !fifo_full;
      e_wr             = req_valid[m_owner] && !fifo_full;
      if (e_wr && q[m_owner].size() > 0) e_data = q[m_owner][0];
    end
  endtask

  // Apply this cycle's inputs to the model, then move to the next cycle.
  task automatic advance();
    if (m_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_last + i) % N;
        if (req_valid[c]) begin
          m_owner = c;
          m_last  = c;
          m_cnt   = 0;
          break;
        end
      end
    end else if (!req_valid[m_owner]) begin
      m_owner = -1;
    end else if (!fifo_full) begin
      void'(q[m_owner].pop_front());
      m_words[m_owner]++;
      m_cnt++;
      if (m_cnt == MB) m_owner = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_owner = -1;
    m_last  = N - 1;
    m_cnt   = 0;
    for (int k = 0; k < N; k++) m_words[k] = 0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) q[k].delete();
    model_clear();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    req_data  = {N{rnd_word()}};
    fifo_full = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b expected 0", busy);
    end
    checks++;
    if (grant !== '0) begin
      errors++;
      $display("FAIL reset_grant got %b expected 0000", grant);
    end
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready got %b expected 0000", req_ready);
    end
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_wr_en got %b expected 0", wr_en);
    end
    checks++;
    if (word_cnt !== '0) begin
      errors++;
      $display("FAIL reset_word_cnt got %h expected 0", word_cnt);
    end
    rst = 1'b0;
    #1;
    // The first cycle out of reset is the arbitration cycle. No word moves yet.
    checks++;
    if ({busy, wr_en, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_first_idle busy/wr/ready got %b expected 0", {busy, wr_en, req_ready});
    end
  endtask

  task automatic test_single_burst();
    int nbursts, nwr;
    logic [N-1:0] prev;
    do_reset();
    for (int i = 0; i < 10; i++) q[1].push_back(rnd_word());
    full_pct = 0;
    drop_en  = 0;
    nbursts  = 0;
    nwr      = 0;
    prev     = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      drive();
      #1;
      model_expect();
      checks++;
      if ({busy, grant, req_ready, wr_en} !== {e_busy, e_grant, e_ready, e_wr}) begin
        errors++;
        $display("FAIL single_ctrl cyc=%0d busy/grant/ready/wr got %b expected %b", cyc,
                 {busy, grant, req_ready, wr_en}, {e_busy, e_grant, e_ready, e_wr});
      end
      if (e_wr) begin
        checks++;
        if (wr_data !== e_data) begin
          errors++;
          $display("FAIL single_data cyc=%0d got %h expected %h", cyc, wr_data, e_data);
        end
      end
      if (grant !== '0 && prev === '0) nbursts++;
      if (wr_en === 1'b1) nwr++;
      prev = grant;
      advance();
    end
    checks++;
    if (nbursts != 3) begin
      errors++;
      $display("FAIL single_bursts got %0d expected 3", nbursts);
    end
    checks++;
    if (nwr != 10) begin
      errors++;
      $display("FAIL single_writes got %0d expected 10", nwr);
    end
  endtask

  task automatic test_round_robin();
    int ng, nwr;
    logic [N-1:0] prev;
    logic [N-1:0] seen [10];
    do_reset();
    for (int k = 0; k < N; k++) for (int i = 0; i < 40; i++) q[k].push_back(rnd_word());
    ng   = 0;
    nwr  = 0;
    prev = '0;
    for (int i = 0; i < 10; i++) seen[i] = '0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      drive();
      #1;
      model_expect();
      checks++;
      if ({busy, grant, req_ready, wr_en} !== {e_busy, e_grant, e_ready, e_wr}) begin
        errors++;
        $display("FAIL rr_ctrl cyc=%0d busy/grant/ready/wr got %b expected %b", cyc,
                 {busy, grant, req_ready, wr_en}, {e_busy, e_grant, e_ready, e_wr});
      end
      if (e_wr) begin
        checks++;
        if (wr_data !== e_data) begin
          errors++;
          $display("FAIL rr_data cyc=%0d got %h expected %h", cyc, wr_data, e_data);
        end
      end
      if (grant !== '0 && prev === '0) begin
        if (ng < 10) seen[ng] = grant;
        ng++;
      end
      if (wr_en === 1'b1) nwr++;
      prev = grant;
      advance();
    end
    for (int i = 0; i < 10; i++) begin
      logic [N-1:0] want;
      want = '0;
      want[i % N] = 1'b1;
      checks++;
      if (seen[i] !== want) begin
        errors++;
        $display("FAIL rr_order grant#%0d got %b expected %b", i, seen[i], want);
      end
    end
    // 5-cycle period: 1 arbitration cycle + 4 burst cycles
    checks++;
    if (nwr != 40) begin
      errors++;
      $display("FAIL rr_duty writes in 50 cycles got %0d expected 40", nwr);
    end
  endtask

  task automatic test_full_stall();
    int nwr, stall;
    bit stalled;
    do_reset();
    for (int i = 0; i < 4; i++) q[0].push_back(rnd_word());
    full_pct  = -1;
    fifo_full = 1'b0;
    nwr       = 0;
    stall     = 0;
    stalled   = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (nwr == 2 && !stalled) begin
        stalled = 1;
        stall   = 6;
      end
      fifo_full = (stall > 0);
      if (stall > 0) stall--;
      drive();
      #1;
      model_expect();
      checks++;
      if ({busy, grant, req_ready, wr_en} !== {e_busy, e_grant, e_ready, e_wr}) begin
        errors++;
        $display("FAIL stall_ctrl cyc=%0d busy/grant/ready/wr got %b expected %b", cyc,
                 {busy, grant, req_ready, wr_en}, {e_busy, e_grant, e_ready, e_wr});
      end
      if (e_wr) begin
        checks++;
        if (wr_data !== e_data) begin
          errors++;
          $display("FAIL stall_data cyc=%0d got %h expected %h", cyc, wr_data, e_data);
        end
      end
      if (fifo_full) begin
        checks++;
        if (wr_en !== 1'b0 || req_ready !== '0 || grant !== 4'b0001) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d wr/ready/grant got %b expected 0_0000_0001", cyc,
                   {wr_en, req_ready, grant});
        end
      end
      if (wr_en === 1'b1) nwr++;
      advance();
    end
    fifo_full = 1'b0;
    full_pct  = 0;
    checks++;
    if (nwr != 4) begin
      errors++;
      $display("FAIL stall_writes got %0d expected 4", nwr);
    end
  endtask

  task automatic test_release();
    logic [N-1:0] want [3];
    logic [N-1:0] seen [3];
    logic [N-1:0] prev;
    int ng;
    bit pushed;
    for (int v = 0; v < 2; v++) begin
      do_reset();
      q[2].push_back(rnd_word());
      want[0] = 4'b0100;
      want[1] = (v == 0) ? 4'b1000 : 4'b0001;
      want[2] = (v == 0) ? 4'b0001 : 4'b0010;
      for (int i = 0; i < 3; i++) seen[i] = '0;
      ng     = 0;
      pushed = 0;
      prev   = '0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        drive();
        #1;
        model_expect();
        checks++;
        if ({busy, grant, req_ready, wr_en} !== {e_busy, e_grant, e_ready, e_wr}) begin
          errors++;
          $display("FAIL release_ctrl v=%0d cyc=%0d busy/grant/ready/wr got %b expected %b", v,
                   cyc, {busy, grant, req_ready, wr_en}, {e_busy, e_grant, e_ready, e_wr});
        end
        if (e_wr) begin
          checks++;
          if (wr_data !== e_data) begin
            errors++;
            $display("FAIL release_data v=%0d cyc=%0d got %h expected %h", v, cyc, wr_data,
                     e_data);
          end
        end
        if (grant !== '0 && prev === '0) begin
          if (ng < 3) seen[ng] = grant;
          ng++;
        end
        prev = grant;
        if (!pushed && grant === 4'b0100) begin
          pushed = 1;
          for (int i = 0; i < 3; i++) begin
            if (v == 0) q[3].push_back(rnd_word());
            else        q[1].push_back(rnd_word());
            q[0].push_back(rnd_word());
          end
        end
        advance();
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (seen[i] !== want[i]) begin
          errors++;
          $display("FAIL release_order v=%0d grant#%0d got %b expected %b", v, i, seen[i],
                   want[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int nwr;
    logic [N-1:0] first;
    do_reset();
    for (int k = 0; k < N; k++) for (int i = 0; i < 20; i++) q[k].push_back(rnd_word());
    nwr = 0;
    for (int cyc = 0; cyc < 20 && nwr < 2; cyc++) begin
      drive();
      #1;
      if (wr_en === 1'b1) nwr++;
      advance();
    end
    checks++;
    if (nwr != 2) begin
      errors++;
      $display("FAIL midrst_setup writes got %0d expected 2", nwr);
    end
    rst = 1'b1;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    drive();
    #1;
    checks++;
    if ({busy, grant, req_ready, wr_en} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs busy/grant/ready/wr got %b expected 0",
               {busy, grant, req_ready, wr_en});
    end
    checks++;
    if (word_cnt !== '0) begin
      errors++;
      $display("FAIL midrst_word_cnt got %h expected 0", word_cnt);
    end
    advance();
    first = '0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive();
      #1;
      model_expect();
      checks++;
      if ({busy, grant, req_ready, wr_en} !== {e_busy, e_grant, e_ready, e_wr}) begin
        errors++;
        $display("FAIL midrst_ctrl cyc=%0d busy/grant/ready/wr got %b expected %b", cyc,
                 {busy, grant, req_ready, wr_en}, {e_busy, e_grant, e_ready, e_wr});
      end
      if (first === '0) first = grant;
      advance();
    end
    checks++;
    if (first !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_first_grant got %b expected 0001", first);
    end
  endtask

  task automatic test_random();
    do_reset();
    drop_en  = 1;
    full_pct = 30;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (q[k].size() == 0 && $urandom_range(0, 3) == 0) begin
          int n;
          n = $urandom_range(1, 8);
          for (int i = 0; i < n; i++) q[k].push_back(rnd_word());
        end
      end
      drive();
      #1;
      model_expect();
      checks++;
      if ({busy, grant, req_ready, wr_en} !== {e_busy, e_grant, e_ready, e_wr}) begin
        errors++;
        $display("FAIL random_ctrl cyc=%0d busy/grant/ready/wr got %b expected %b", cyc,
                 {busy, grant, req_ready, wr_en}, {e_busy, e_grant, e_ready, e_wr});
      end
      if (e_wr) begin
        checks++;
        if (wr_data !== e_data) begin
          errors++;
          $display("FAIL random_data cyc=%0d got %h expected %h", cyc, wr_data, e_data);
        end
      end
      advance();
    end
    drop_en  = 0;
    full_pct = 0;
  endtask

  task automatic test_stats();
    int nwr;
    do_reset();
    for (int k = 0; k < N; k++) for (int i = 0; i < 40; i++) q[k].push_back(rnd_word());
    nwr = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      drive();
      #1;
      if (wr_en === 1'b1) nwr++;
      advance();
    end
    checks++;
    if (nwr != 80) begin
      errors++;
      $display("FAIL stats_writes got %0d expected 80", nwr);
    end
`ifdef FIFO_ARB_STATS_EN
    begin
      longint sum;
      sum = 0;
      for (int k = 0; k < N; k++) begin
        sum += longint'(word_cnt[k*32 +: 32]);
        checks++;
        if (word_cnt[k*32 +: 32] !== 32'(m_words[k])) begin
          errors++;
          $display("FAIL stats_cnt%0d got %0d expected %0d", k, word_cnt[k*32 +: 32], m_words[k]);
        end
        for (int j = 0; j < N; j++) begin
          longint d;
          d = longint'(word_cnt[k*32 +: 32]) - longint'(word_cnt[j*32 +: 32]);
          if (j > k) begin
            checks++;
            if (d > 4 || d < -4) begin
              errors++;
              $display("FAIL stats_balance cnt%0d-cnt%0d got %0d expected within 4", k, j, d);
            end
          end
        end
      end
      checks++;
      if (sum != longint'(nwr)) begin
        errors++;
        $display("FAIL stats_sum got %0d expected %0d", sum, nwr);
      end
    end
`else
    checks++;
    if (word_cnt !== '0) begin
      errors++;
      $display("FAIL stats_disabled word_cnt got %h expected 0", word_cnt);
    end
`endif
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    drop_en   = 0;
    full_pct  = 0;
    model_clear();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_release();
    test_reset_mid_burst();
    test_random();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
